mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates a single data-memory port between two requesters: instruction fetch (IFU) and load/store (LSU).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Exactly one transaction is outstanding at a time, and it is held to completion before the next grant.
- Round-robin on contention; a timeout counter returns an error response if memory never answers.

Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- TIMEOUT, 255, maximum cycles in WAIT before an error response; 1..65535

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU request pending
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  AW  IFU address (read only)
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_rdata  out  DW  IFU read data
- ifu_err  out  1  IFU response is timeout error
- lsu_req_valid  in  1  LSU request pending
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  AW  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DW  write data
- lsu_wmask  in  DW/8  byte write mask
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU consumes response
- lsu_rdata  out  DW  LSU read data (0 for writes)
- lsu_err  out  1  LSU response is timeout error
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  DW  latched write data
- mem_wmask  out  DW/8  latched mask (all 0 for IFU)
- mem_resp_valid  in  1  memory response strobe
- mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: clk; rst is synchronous and active-high.
- States: IDLE, REQ, WAIT, RESP. Registers: state, owner (0 = IFU, 1 = LSU), last_grant, latched request fields, rdata_q, err_q, tcnt.
- Reset:
  - state = IDLE, last_grant = IFU (so the first tie goes to LSU), tcnt = 0, rdata_q = 0, err_q = 0.
  - All *_valid and *_ready outputs = 0; mem_* data outputs = 0.
- Reset mid-transaction: the transaction is dropped with no response. A memory response arriving after reset is ignored in IDLE.
- IDLE:
  - Grant selection: if only one requester is valid, it is granted. If both are valid, grant the one that is not last_grant.
  - Combinational ready: granted requester's req_ready = 1; the other's = 0. If no requester is valid, both = 0.
  - On grant: latch addr, wen, wdata, and wmask (IFU forces wen = 0 and wmask = 0). Set owner and last_grant = owner, tcnt = 0, then go to REQ.
- REQ:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
  - If mem_resp_valid arrives in the same cycle as mem_req_ready, capture it and go directly to RESP.
- WAIT:
  - mem_req_valid = 0; tcnt increments each cycle.
  - On mem_resp_valid: rdata_q = (wen ? 0 : mem_rdata), err_q = 0, go to RESP.
  - Else if tcnt == TIMEOUT-1: rdata_q = 0, err_q = 1, go to RESP.
  - mem_resp_valid has priority over timeout in the same cycle.
- RESP:
  - Owner's resp_valid = 1 with rdata_q and err_q; the non-owner's resp_valid = 0.
  - Hold until the owner's resp_ready, then go to IDLE.
  - A new grant is possible the cycle after RESP.
- Latency: minimum 3 cycles from request acceptance to resp_valid with a zero-wait memory: accept → REQ → RESP.
- Both req_ready outputs are 0 in REQ, WAIT, and RESP; requesters hold valid and fields until ready.
- Stray mem_resp_valid in IDLE, RESP, or REQ without mem_req_ready is ignored.
- *_rdata and *_err outputs are driven from rdata_q and err_q at all times; valid qualifies them.

Test Plan:
- Single IFU read of 0x80000000, memory returns 0x00100073 two cycles after accept → ifu_req_ready pulses once, mem_wmask = 0, ifu_resp_valid with ifu_rdata = 0x00100073, ifu_err = 0; lsu outputs stay 0.
- Both valid on the first cycle after reset → LSU granted first. The next tie grants IFU, then LSU: strict alternation over 6 back-to-back tied requests.
- LSU write addr 0x80000010, wdata 0xA5A5A5A5, wmask 0x3 → mem_wen = 1 and fields stable during REQ with mem_req_ready held low 4 cycles; lsu_rdata = 0, lsu_err = 0.
- Memory never responds, TIMEOUT = 8 → lsu_resp_valid asserts exactly 8 cycles after entering WAIT, with lsu_err = 1 and lsu_rdata = 0.
- rst asserted during WAIT, then a late mem_resp_valid arrives → no resp_valid on either port; the next IFU request completes normally.
- Response backpressure: ifu_resp_ready low 5 cycles → ifu_resp_valid and ifu_rdata held constant; a pending lsu_req_valid sees lsu_req_ready = 0 until the cycle after IFU consumes.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two requesters (IFU, LSU), the arbiter
// and the shared data-memory port. The arbiter uses the slave view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ifu_req_valid;
    logic          ifu_req_ready;
    logic [AW-1:0] ifu_addr;
    logic          ifu_resp_valid;
    logic          ifu_resp_ready;
    logic [DW-1:0] ifu_rdata;
    logic          ifu_err;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [AW-1:0]   lsu_addr;
    logic            lsu_wen;
    logic [DW-1:0]   lsu_wdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            lsu_resp_valid;
    logic            lsu_resp_ready;
    logic [DW-1:0]   lsu_rdata;
    logic            lsu_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wmask;
    logic            mem_resp_valid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for one data-memory port: one outstanding
// transaction, round-robin on ties, timeout error if memory never answers.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    state_t          state_r;
    state_t          state_s;
    logic            owner_r;
    logic            last_grant_r;
    logic [AW-1:0]   addr_r;
    logic            wen_r;
    logic [DW-1:0]   wdata_r;
    logic [DW/8-1:0] wmask_r;
    logic [DW-1:0]   rdata_r;
    logic            err_r;
    logic [15:0]     tcnt_r;

    logic grant_any_s;
    logic grant_lsu_s;
    logic ifu_req_ready_s;
    logic lsu_req_ready_s;
    logic mem_req_valid_s;
    logic ifu_resp_valid_s;
    logic lsu_resp_valid_s;
    logic resp_done_s;

    // On a tie, LSU wins unless it was the previous owner.
    assign grant_any_s = bus.ifu_req_valid | bus.lsu_req_valid;
    assign grant_lsu_s = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_grant_r);
    assign resp_done_s = owner_r ? bus.lsu_resp_ready : bus.ifu_resp_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_s          = state_r;
        ifu_req_ready_s  = 1'b0;
        lsu_req_ready_s  = 1'b0;
        mem_req_valid_s  = 1'b0;
        ifu_resp_valid_s = 1'b0;
        lsu_resp_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                ifu_req_ready_s = bus.ifu_req_valid & ~grant_lsu_s;
                lsu_req_ready_s = grant_lsu_s;
                if (grant_any_s) state_s = REQ;
                else             state_s = IDLE;
            end
            REQ: begin
                mem_req_valid_s = 1'b1;
                if (bus.mem_req_ready && bus.mem_resp_valid) state_s = RESP;
                else if (bus.mem_req_ready)                  state_s = WAIT;
                else                                         state_s = REQ;
            end
            WAIT: begin
                if (bus.mem_resp_valid || (tcnt_r == TCNT_LAST)) state_s = RESP;
                else                                             state_s = WAIT;
            end
            RESP: begin
                ifu_resp_valid_s = ~owner_r;
                lsu_resp_valid_s = owner_r;
                if (resp_done_s) state_s = IDLE;
                else             state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Grant bookkeeping, request latch, response capture and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b0;
            addr_r       <= {AW{1'b0}};
            wen_r        <= 1'b0;
            wdata_r      <= {DW{1'b0}};
            wmask_r      <= {(DW/8){1'b0}};
            rdata_r      <= {DW{1'b0}};
            err_r        <= 1'b0;
            tcnt_r       <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        owner_r      <= grant_lsu_s;
                        last_grant_r <= grant_lsu_s;
                        tcnt_r       <= 16'd0;
                        if (grant_lsu_s) begin
                            addr_r  <= bus.lsu_addr;
                            wen_r   <= bus.lsu_wen;
                            wdata_r <= bus.lsu_wdata;
                            wmask_r <= bus.lsu_wmask;
                        end else begin
                            addr_r  <= bus.ifu_addr;
                            wen_r   <= 1'b0;
                            wdata_r <= {DW{1'b0}};
                            wmask_r <= {(DW/8){1'b0}};
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready && bus.mem_resp_valid) begin
                        rdata_r <= wen_r ? {DW{1'b0}} : bus.mem_rdata;
                        err_r   <= 1'b0;
                    end
                end
                WAIT: begin
                    tcnt_r <= tcnt_r + 16'd1;
                    if (bus.mem_resp_valid) begin
                        rdata_r <= wen_r ? {DW{1'b0}} : bus.mem_rdata;
                        err_r   <= 1'b0;
                    end else if (tcnt_r == TCNT_LAST) begin
                        rdata_r <= {DW{1'b0}};
                        err_r   <= 1'b1;
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ifu_req_ready  = ifu_req_ready_s;
    assign bus.lsu_req_ready  = lsu_req_ready_s;
    assign bus.ifu_resp_valid = ifu_resp_valid_s;
    assign bus.lsu_resp_valid = lsu_resp_valid_s;
    assign bus.ifu_rdata      = rdata_r;
    assign bus.lsu_rdata      = rdata_r;
    assign bus.ifu_err        = err_r;
    assign bus.lsu_err        = err_r;
    assign bus.mem_req_valid  = mem_req_valid_s;
    assign bus.mem_addr       = addr_r;
    assign bus.mem_wen        = wen_r;
    assign bus.mem_wdata      = wdata_r;
    assign bus.mem_wmask      = wmask_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of whole transactions plus hand-written
// sequences for backpressure with a pending requester and reset during WAIT.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifu_v;
        logic        lsu_v;
        logic [31:0] ifu_addr;
        logic [31:0] lsu_addr;
        logic        lsu_wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          req_stall;  // cycles mem_req_ready stays low in REQ
        int          resp_dly;   // WAIT cycles incl. response; 0 = with req_ready; -1 = never
        logic [31:0] mem_data;
        int          bp;         // cycles resp_ready stays low in RESP
        logic        exp_lsu;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] ea;
        logic        ew;
        logic [3:0]  em;
        int          cnt;
        ea = v.exp_lsu ? v.lsu_addr : v.ifu_addr;
        ew = v.exp_lsu ? v.lsu_wen : 1'b0;
        em = v.exp_lsu ? v.wmask : 4'h0;

        bus.ifu_req_valid = v.ifu_v;
        bus.ifu_addr      = v.ifu_addr;
        bus.lsu_req_valid = v.lsu_v;
        bus.lsu_addr      = v.lsu_addr;
        bus.lsu_wen       = v.lsu_wen;
        bus.lsu_wdata     = v.wdata;
        bus.lsu_wmask     = v.wmask;
        #1;
        chk($sformatf("v%0d_grant", idx), {bus.ifu_req_ready, bus.lsu_req_ready}, {~v.exp_lsu, v.exp_lsu});
        step();
        if (v.exp_lsu) bus.lsu_req_valid = 1'b0;
        else           bus.ifu_req_valid = 1'b0;

        for (int s = 0; s <= v.req_stall; s++) begin
            #1;
            chk($sformatf("v%0d_req", idx),
                {bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr, bus.ifu_req_ready, bus.lsu_req_ready},
                {1'b1, ew, em, ea, 2'b00});
            if (v.exp_lsu) chk($sformatf("v%0d_wdata", idx), bus.mem_wdata, v.wdata);
            bus.mem_req_ready = (s == v.req_stall);
            if (s == v.req_stall && v.resp_dly == 0) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_rdata      = v.mem_data;
            end
            step();
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = 32'hFFFF_FFFF;
        end

        if (v.resp_dly > 0) begin
            for (int w = 1; w <= v.resp_dly; w++) begin
                chk($sformatf("v%0d_wait", idx), {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid}, 3'b000);
                if (w == v.resp_dly) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = v.mem_data;
                end
                step();
                bus.mem_resp_valid = 1'b0;
                bus.mem_rdata      = 32'hFFFF_FFFF;
            end
        end else if (v.resp_dly < 0) begin
            cnt = 0;
            while (!(bus.ifu_resp_valid || bus.lsu_resp_valid) && cnt < 40) begin
                step();
                cnt++;
            end
            chk($sformatf("v%0d_timeout_cycles", idx), cnt, TO);
        end

        for (int b = 0; b <= v.bp; b++) begin
            chk($sformatf("v%0d_resp", idx),
                {bus.ifu_resp_valid, bus.lsu_resp_valid,
                 (v.exp_lsu ? bus.lsu_rdata : bus.ifu_rdata), (v.exp_lsu ? bus.lsu_err : bus.ifu_err)},
                {~v.exp_lsu, v.exp_lsu, v.exp_rdata, v.exp_err});
            if (b < v.bp) step();
        end
        if (v.exp_lsu) bus.lsu_resp_ready = 1'b1;
        else           bus.ifu_resp_ready = 1'b1;
        step();
        bus.ifu_resp_ready = 1'b0;
        bus.lsu_resp_ready = 1'b0;
        chk($sformatf("v%0d_resp_done", idx), {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tail;
        n_checks = 0;
        n_errors = 0;
        //          ifu  lsu  ifu_addr      lsu_addr      wen   wdata         mask  stl dly data          bp lsu   rdata         err
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0100, 1'b0, 32'h0,        4'h0, 0, 0, 32'h1111_1111, 0, 1'b1, 32'h1111_1111, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0204, 32'h0000_0104, 1'b0, 32'h0,        4'h0, 0, 1, 32'h2222_2222, 0, 1'b0, 32'h2222_2222, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0208, 32'h0000_0108, 1'b1, 32'hDEAD_BEEF, 4'hF, 1, 2, 32'h3333_3333, 0, 1'b1, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_020C, 32'h0000_010C, 1'b0, 32'h0,        4'h0, 1, 0, 32'h4444_4444, 0, 1'b0, 32'h4444_4444, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0210, 32'h0000_0110, 1'b0, 32'h0,        4'h0, 2, 3, 32'h5555_5555, 1, 1'b1, 32'h5555_5555, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0214, 32'h0000_0114, 1'b1, 32'h1234_5678, 4'hF, 0, 1, 32'h6666_6666, 0, 1'b0, 32'h6666_6666, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         1'b0, 32'h0,        4'h0, 0, 1, 32'h0010_0073, 0, 1'b0, 32'h0010_0073, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'h0,         32'h8000_0010, 1'b1, 32'hA5A5_A5A5, 4'h3, 4, 1, 32'hCAFE_F00D, 0, 1'b1, 32'h0,         1'b0};
        vecs[8] = '{1'b0, 1'b1, 32'h0,         32'h8000_0020, 1'b0, 32'h0,        4'h0, 0, -1, 32'h0,        0, 1'b1, 32'h0,         1'b1};
        vecs[9] = '{1'b0, 1'b1, 32'h0,         32'h8000_0024, 1'b0, 32'h0,        4'h0, 0, 1, 32'h89AB_CDEF, 2, 1'b1, 32'h89AB_CDEF, 1'b0};

        rst = 1'b1;
        bus.ifu_req_valid = 1'b0; bus.ifu_addr = 32'h0; bus.ifu_resp_ready = 1'b0;
        bus.lsu_req_valid = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wen = 1'b0;
        bus.lsu_wdata = 32'h0; bus.lsu_wmask = 4'h0; bus.lsu_resp_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
        step(); step(); step();
        chk("reset_valid_ready",
            {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid}, 5'b00000);
        chk("reset_mem_fields", {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask}, 69'h0);
        chk("reset_rdata_err", {bus.ifu_rdata, bus.ifu_err, bus.lsu_rdata, bus.lsu_err}, 66'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // IFU response held off while LSU waits for its grant.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0100;
        step();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_0200;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wmask     = 4'h0;
        #1;
        chk("bp_lsu_ready_req", bus.lsu_req_ready, 1'b0);
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h0BAD_F00D;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'hFFFF_FFFF;
        for (int b = 0; b < 5; b++) begin
            chk("bp_hold", {bus.ifu_resp_valid, bus.ifu_rdata, bus.ifu_err, bus.lsu_req_ready},
                {1'b1, 32'h0BAD_F00D, 1'b0, 1'b0});
            bus.mem_resp_valid = (b == 2);
            step();
            bus.mem_resp_valid = 1'b0;
        end
        bus.ifu_resp_ready = 1'b1;
        #1;
        chk("bp_lsu_ready_consume_cycle", bus.lsu_req_ready, 1'b0);
        step();
        bus.ifu_resp_ready = 1'b0;
        #1;
        chk("bp_lsu_ready_after", {bus.lsu_req_ready, bus.ifu_resp_valid}, 2'b10);
        step();
        bus.lsu_req_valid  = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'h1357_9BDF;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'hFFFF_FFFF;
        chk("bp_lsu_resp", {bus.lsu_resp_valid, bus.lsu_rdata, bus.lsu_err}, {1'b1, 32'h1357_9BDF, 1'b0});
        bus.lsu_resp_ready = 1'b1;
        step();
        bus.lsu_resp_ready = 1'b0;
        chk("bp_lsu_done", bus.lsu_resp_valid, 1'b0);

        // Reset while waiting on memory, then a late response.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h0000_0300;
        step();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_state", {bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_addr, bus.ifu_rdata},
            67'h0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 32'hBAD0_BAD0;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            chk("rst_late_resp_ignored", {bus.ifu_resp_valid, bus.lsu_resp_valid, bus.mem_req_valid, bus.ifu_rdata},
                35'h0);
            step();
        end
        tail = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, 32'h0, 4'h0, 0, 1, 32'h7777_7777, 0, 1'b0, 32'h7777_7777, 1'b0};
        run_vec(10, tail);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
